// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction buffer.
// The buffer uses the slave modport; the fetch/decode side uses master.
interface if_id_buffer_if #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  in_valid;
  logic [PC_WIDTH-1:0]   in_pc;
  logic [PC_WIDTH-1:0]   in_pc_next;
  logic [INST_WIDTH-1:0] in_inst;
  logic                  in_ready;
  logic                  out_ready;
  logic                  out_valid;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [PC_WIDTH-1:0]   out_pc_next;
  logic [INST_WIDTH-1:0] out_inst;
  logic [CW-1:0]         count;

  modport slave (
    input  flush, in_valid, in_pc, in_pc_next, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_pc_next, out_inst, count
  );

  modport master (
    output flush, in_valid, in_pc, in_pc_next, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_next, out_inst, count
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID circular instruction buffer with valid/ready handshake and flush.
// Optional IF_ID_NOP_FILL_EN: present a NOP bubble (pc fields 0) while empty.
module if_id_buffer #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter int unsigned         INST_WIDTH = 32,
  parameter int unsigned         DEPTH      = 2,
  parameter logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h0000_0013)
) (
  input logic            clk,
  input logic            reset,
  if_id_buffer_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef IF_ID_NOP_FILL_EN
  localparam bit NOP_FILL = 1'b1;
`else
  localparam bit NOP_FILL = 1'b0;
`endif

  logic [PC_WIDTH-1:0]   pc_q      [DEPTH];
  logic [PC_WIDTH-1:0]   pc_next_q [DEPTH];
  logic [INST_WIDTH-1:0] inst_q    [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign bus.in_ready  = (count_q != FULL);
  assign bus.out_valid = (count_q != '0);
  assign bus.count     = count_q;

  // Flush suppresses both transfers so nothing is written or consumed on that edge.
  assign push = bus.in_valid  & bus.in_ready  & ~bus.flush;
  assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (bus.flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Flush only drops validity; stored entries are left in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]      <= '0;
        pc_next_q[i] <= '0;
        inst_q[i]    <= '0;
      end
    end else if (push) begin
      pc_q[wp_q]      <= bus.in_pc;
      pc_next_q[wp_q] <= bus.in_pc_next;
      inst_q[wp_q]    <= bus.in_inst;
    end
  end

  always_comb begin
    if (NOP_FILL && !bus.out_valid) begin
      bus.out_pc      = '0;
      bus.out_pc_next = '0;
      bus.out_inst    = NOP_INST;
    end else begin
      bus.out_pc      = pc_q[rp_q];
      bus.out_pc_next = pc_next_q[rp_q];
      bus.out_inst    = inst_q[rp_q];
    end
  end
endmodule
